// File: rtl/regfile_pkg.sv
// Shared defaults and request type for the register-file write scheduler.
package regfile_pkg;

  localparam int unsigned DefaultDataWidth   = 32;
  localparam int unsigned DefaultAddressSize = 5;

  typedef struct packed {
    logic [DefaultAddressSize-1:0] address;
    logic [DefaultDataWidth-1:0]   data;
  } write_request_t;

endpackage

// File: rtl/write_request_fifo.sv
// Synchronous FIFO for deferred register writes; exposes per-entry valid/address taps.
module write_request_fifo #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 5,
  parameter int unsigned Depth     = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             push_valid_i,
  output logic                             push_ready_o,
  input  logic [AddrWidth-1:0]             push_addr_i,
  input  logic [DataWidth-1:0]             push_data_i,
  input  logic                             pop_i,
  output logic                             head_valid_o,
  output logic [AddrWidth-1:0]             head_addr_o,
  output logic [DataWidth-1:0]             head_data_o,
  output logic [Depth-1:0]                 entry_valid_o,
  output logic [Depth-1:0][AddrWidth-1:0]  entry_addr_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] PtrOne = 1;

  logic [PtrW:0]                    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [Depth-1:0]                 valid_q, valid_d;
  logic [Depth-1:0][AddrWidth-1:0]  addr_q, addr_d;
  logic [Depth-1:0][DataWidth-1:0]  data_q, data_d;
  logic                             full, empty, push, pop;

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                 (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign push_ready_o = !full && !rst_i;
  assign push         = push_valid_i && push_ready_o;
  assign pop          = pop_i && !empty;

  assign head_valid_o  = !empty;
  assign head_addr_o   = addr_q[rd_ptr_q[PtrW-1:0]];
  assign head_data_o   = data_q[rd_ptr_q[PtrW-1:0]];
  assign entry_valid_o = valid_q;
  assign entry_addr_o  = addr_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    valid_d  = valid_q;
    addr_d   = addr_q;
    data_d   = data_q;
    if (push) begin
      addr_d[wr_ptr_q[PtrW-1:0]]  = push_addr_i;
      data_d[wr_ptr_q[PtrW-1:0]]  = push_data_i;
      valid_d[wr_ptr_q[PtrW-1:0]] = 1'b1;
      wr_ptr_d                    = wr_ptr_q + PtrOne;
    end
    if (pop) begin
      valid_d[rd_ptr_q[PtrW-1:0]] = 1'b0;
      rd_ptr_d                    = rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= '0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Arbitrates the register-file write port: pipeline first, buffered unit results in idle slots.
module regfile_write_scheduler
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DefaultDataWidth,
  parameter int unsigned ADDRESS_SIZE = DefaultAddressSize,
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                         system_clock,
  input  logic                         reset,
  input  logic                         pipe_valid,
  input  logic [ADDRESS_SIZE-1:0]      pipe_address,
  input  logic [DATA_WIDTH-1:0]        pipe_data,
  input  logic                         unit_valid,
  output logic                         unit_ready,
  input  logic [ADDRESS_SIZE-1:0]      unit_address,
  input  logic [DATA_WIDTH-1:0]        unit_data,
  output logic                         write_enable,
  output logic [ADDRESS_SIZE-1:0]      write_address,
  output logic [DATA_WIDTH-1:0]        write_data,
  output logic [2**ADDRESS_SIZE-1:0]   pending_mask,
  output logic                         stall_pipeline,
  output logic                         conflict_error
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] Limit  = CntW'(STARVE_LIMIT);
  localparam logic [CntW-1:0] CntOne = 1;

  logic                                    pipe_write, unit_push, pop;
  logic                                    head_valid;
  logic [ADDRESS_SIZE-1:0]                 head_addr;
  logic [DATA_WIDTH-1:0]                   head_data;
  logic [FIFO_DEPTH-1:0]                   entry_valid;
  logic [FIFO_DEPTH-1:0][ADDRESS_SIZE-1:0] entry_addr;
  logic [CntW-1:0]                         cnt_q, cnt_d;
  logic                                    stall_q, stall_d;
  logic                                    conflict_q, conflict_d;

  // r0 is hardwired: pipe writes to it never take the port, unit writes to it are dropped.
  assign pipe_write = pipe_valid && (pipe_address != '0) && !reset;
  assign unit_push  = unit_valid && (unit_address != '0);
  assign pop        = head_valid && !pipe_write;

  write_request_fifo #(
    .DataWidth (DATA_WIDTH),
    .AddrWidth (ADDRESS_SIZE),
    .Depth     (FIFO_DEPTH)
  ) u_fifo (
    .clk_i         (system_clock),
    .rst_i         (reset),
    .push_valid_i  (unit_push),
    .push_ready_o  (unit_ready),
    .push_addr_i   (unit_address),
    .push_data_i   (unit_data),
    .pop_i         (pop),
    .head_valid_o  (head_valid),
    .head_addr_o   (head_addr),
    .head_data_o   (head_data),
    .entry_valid_o (entry_valid),
    .entry_addr_o  (entry_addr)
  );

  always_comb begin
    write_enable  = 1'b0;
    write_address = '0;
    write_data    = '0;
    if (pipe_write) begin
      write_enable  = 1'b1;
      write_address = pipe_address;
      write_data    = pipe_data;
    end else if (head_valid) begin
      write_enable  = 1'b1;
      write_address = head_addr;
      write_data    = head_data;
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (entry_valid[i]) pending_mask[entry_addr[i]] = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!head_valid || pop) begin
      cnt_d = '0;
    end else if (cnt_q != Limit) begin
      cnt_d = cnt_q + CntOne;
    end
    stall_d    = (cnt_q == Limit) && head_valid && !pop;
    conflict_d = conflict_q || (pipe_write && pending_mask[pipe_address]);
  end

  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      stall_q    <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      stall_q    <= stall_d;
      conflict_q <= conflict_d;
    end
  end

  assign stall_pipeline = stall_q;
  assign conflict_error = conflict_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Scoreboard bench: a queue-based model predicts port writes and status; a monitor checks them.
module tb_regfile_write_scheduler;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;
  localparam int NREG = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pipe_valid = 1'b0, unit_valid = 1'b0;
  logic [AW-1:0] pipe_address = '0, unit_address = '0;
  logic [DW-1:0] pipe_data = '0, unit_data = '0;
  logic unit_ready, write_enable, stall_pipeline, conflict_error;
  logic [AW-1:0] write_address;
  logic [DW-1:0] write_data;
  logic [NREG-1:0] pending_mask;

  always #5 clk = ~clk;

  regfile_write_scheduler #(
    .DATA_WIDTH   (DW),
    .ADDRESS_SIZE (AW),
    .FIFO_DEPTH   (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .system_clock   (clk),
    .reset          (rst),
    .pipe_valid     (pipe_valid),
    .pipe_address   (pipe_address),
    .pipe_data      (pipe_data),
    .unit_valid     (unit_valid),
    .unit_ready     (unit_ready),
    .unit_address   (unit_address),
    .unit_data      (unit_data),
    .write_enable   (write_enable),
    .write_address  (write_address),
    .write_data     (write_data),
    .pending_mask   (pending_mask),
    .stall_pipeline (stall_pipeline),
    .conflict_error (conflict_error)
  );

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } req_t;
  typedef struct { int cyc; logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct { int cyc; bit ready; logic [NREG-1:0] mask; bit stall; bit conflict; } st_t;

  wr_t  wr_q[$];
  st_t  st_q[$];
  req_t mq[$];
  int   m_wait = 0;
  bit   m_stall = 0, m_conflict = 0;
  int   cyc = 0;
  int   violations = 0;
  int   n_tests = 0, n_fail = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle of stimulus plus the model's view of that cycle.
  task automatic step(input bit r, input bit pv, input logic [AW-1:0] pa,
                      input logic [DW-1:0] pd, input bit uv, input logic [AW-1:0] ua,
                      input logic [DW-1:0] ud, output bit accepted);
    bit ready, pw, popped, nstall;
    logic [NREG-1:0] mask;
    @(posedge clk);
    #1;
    rst = r; pipe_valid = pv; pipe_address = pa; pipe_data = pd;
    unit_valid = uv; unit_address = ua; unit_data = ud;
    cyc++;
    accepted = 0;
    if (r) begin
      mq.delete();
      m_wait = 0; m_stall = 0; m_conflict = 0;
      st_q.push_back('{cyc, 1'b0, '0, 1'b0, 1'b0});
      return;
    end
    ready = (mq.size() < DEPTH);
    mask = '0;
    foreach (mq[i]) mask[mq[i].a] = 1'b1;
    st_q.push_back('{cyc, ready, mask, m_stall, m_conflict});
    if (pv && m_stall) violations++;
    pw = pv && (pa != 0);
    popped = 0;
    if (pw) begin
      wr_q.push_back('{cyc, pa, pd});
      if (mask[pa]) m_conflict = 1;
    end else if (mq.size() > 0) begin
      wr_q.push_back('{cyc, mq[0].a, mq[0].d});
      popped = 1;
    end
    // The head has waited m_wait cycles so far; stall follows once it has waited LIMIT.
    if (mq.size() > 0 && !popped) begin
      nstall = (m_wait >= LIMIT);
      m_wait = (m_wait + 1 > LIMIT) ? LIMIT : m_wait + 1;
    end else begin
      nstall = 0;
      m_wait = 0;
    end
    m_stall = nstall;
    if (popped) void'(mq.pop_front());
    if (uv && ready) begin
      accepted = 1;
      if (ua != 0) mq.push_back('{ua, ud});
    end
  endtask

  st_t st_m;
  wr_t w_m;
  always @(negedge clk) begin
    if (st_q.size() > 0) begin
      st_m = st_q.pop_front();
      check("unit_ready", 64'(unit_ready), 64'(st_m.ready));
      check("pending_mask", 64'(pending_mask), 64'(st_m.mask));
      check("stall_pipeline", 64'(stall_pipeline), 64'(st_m.stall));
      check("conflict_error", 64'(conflict_error), 64'(st_m.conflict));
      if (wr_q.size() > 0 && wr_q[0].cyc == st_m.cyc) begin
        w_m = wr_q.pop_front();
        check("write_enable", 64'(write_enable), 64'd1);
        check("write_address", 64'(write_address), 64'(w_m.a));
        check("write_data", 64'(write_data), 64'(w_m.d));
      end else begin
        check("write_enable_idle", 64'(write_enable), 64'd0);
        check("write_port_idle_zero", {27'd0, write_address, write_data}, 64'd0);
      end
    end
  end

  bit acc;
  bit hold = 0;
  bit uv_r, pv_r;
  logic [AW-1:0] ua_r, pa_r;
  logic [DW-1:0] ud_r, pd_r;

  initial begin
    // Reset, then idle.
    repeat (3) step(1, 0, 0, 0, 0, 0, 0, acc);
    repeat (2) step(0, 0, 0, 0, 0, 0, 0, acc);
    // Unit write with the pipe idle.
    step(0, 0, 0, 0, 1, 5, 32'h1234, acc);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, acc);
    // Pipe hogs the port long enough to starve a buffered result.
    step(0, 1, 3, 32'hAAAA, 1, 7, 32'h5555, acc);
    repeat (7) step(0, 1, 3, 32'hAAAA, 0, 0, 0, acc);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, acc);
    // Three back-to-back results against a busy pipe; the third must wait.
    step(0, 1, 1, 32'h11, 1, 10, 32'hA0, acc);
    step(0, 1, 1, 32'h12, 1, 11, 32'hB0, acc);
    step(0, 1, 1, 32'h13, 1, 12, 32'hC0, acc);
    step(0, 1, 1, 32'h14, 1, 12, 32'hC0, acc);
    step(0, 0, 0, 0, 1, 12, 32'hC0, acc);
    step(0, 0, 0, 0, 1, 12, 32'hC0, acc);
    repeat (2) step(0, 0, 0, 0, 0, 0, 0, acc);
    // Pipe write to r0 leaves the port to the buffered r9.
    step(0, 1, 4, 32'h44, 1, 9, 32'h99, acc);
    step(0, 1, 0, 32'hDEAD, 0, 0, 0, acc);
    repeat (2) step(0, 0, 0, 0, 0, 0, 0, acc);
    // Pipe hits a pending destination; then reset mid-stream.
    step(0, 1, 2, 32'h22, 1, 9, 32'hBEEF, acc);
    step(0, 1, 9, 32'h9999, 0, 0, 0, acc);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, acc);
    step(0, 1, 2, 32'h1, 1, 20, 32'h20, acc);
    step(0, 1, 2, 32'h2, 1, 21, 32'h21, acc);
    repeat (2) step(1, 0, 0, 0, 0, 0, 0, acc);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, acc);
    violations = 0;

    // Random traffic; the unit holds its request until accepted, the pipe honours stall.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 499) == 0) begin
        repeat (2) step(1, 0, 0, 0, 0, 0, 0, acc);
        hold = 0;
        continue;
      end
      if (!hold) begin
        uv_r = ($urandom_range(0, 1) == 1);
        ua_r = ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom_range(1, NREG - 1));
        ud_r = $urandom;
      end
      pv_r = !m_stall && ($urandom_range(0, 9) < 6);
      pa_r = AW'($urandom_range(0, NREG - 1));
      pd_r = $urandom;
      step(0, pv_r, pa_r, pd_r, uv_r, ua_r, ud_r, acc);
      hold = uv_r && !acc;
    end
    repeat (8) step(0, 0, 0, 0, 0, 0, 0, acc);
    @(negedge clk);
    #1;
    check("expected_writes_drained", 64'(wr_q.size()), 64'd0);
    check("random_stall_respected", 64'(violations), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_write_scheduler.md
# regfile_write_scheduler

Shares the single write port of the general purpose register file between the in-order pipeline writeback stage and the multi-cycle execution unit (mul/div, late loads). Pipeline writes have absolute priority and pass through combinationally. Unit results are buffered in a small FIFO and drained into idle write-port cycles. The block also publishes a pending-destination mask for the hazard unit and raises a starvation stall when buffered results wait too long.

## Interface
- DATA_WIDTH, 32, register data width
- ADDRESS_SIZE, 5, register address width; 2**ADDRESS_SIZE registers
- FIFO_DEPTH, 2, unit result buffer entries (power of two, ≥2)
- STARVE_LIMIT, 4, waiting cycles of the FIFO head before stall_pipeline is raised

- system_clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- pipe_valid  in  1  writeback stage write request; no backpressure
- pipe_address  in  ADDRESS_SIZE  writeback destination
- pipe_data  in  DATA_WIDTH  writeback data
- unit_valid  in  1  multi-cycle unit result valid
- unit_ready  out  1  FIFO can accept; transfer on unit_valid && unit_ready
- unit_address  in  ADDRESS_SIZE  unit destination
- unit_data  in  DATA_WIDTH  unit data
- write_enable  out  1  to register file
- write_address  out  ADDRESS_SIZE  to register file
- write_data  out  DATA_WIDTH  to register file
- pending_mask  out  2**ADDRESS_SIZE  bit i set while a buffered entry targets register i
- stall_pipeline  out  1  registered; request that the pipeline withhold pipe_valid
- conflict_error  out  1  sticky; pipe write hit a pending address

## Operation
- Port select, combinational:
  - pipe_valid && pipe_address != 0 drives the port with pipe fields.
  - Otherwise, a non-empty FIFO drives the port with head fields and the head is popped at the clock edge.
  - Otherwise, write_enable = 0 and address/data = 0.
- Writes to address 0 from the pipe are discarded and do not occupy the port.
- Unit handshakes to address 0 complete but are not enqueued.
- unit_ready = !full. It is never asserted in reset. No enqueue occurs when full, even if a pop happens in the same cycle.
- pending_mask is the OR of one-hot decodes of all valid FIFO entries. Entries targeting the same address keep their bit set until the last of them pops.
- Starve counter:
  - Increments each cycle the FIFO is non-empty and the head is not popped.
  - Clears on a pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- stall_pipeline is registered: it is 1 from the cycle after the counter reaches STARVE_LIMIT until the cycle after the head pops.
- If pipe_valid is still asserted while stall_pipeline = 1, the pipe still wins. This is a contract violation, and the bench flags it.
- conflict_error sets when pipe_valid && pipe_address != 0 && pending_mask[pipe_address]. It clears only on reset. Both writes still occur, in priority order.

## Timing
- Reset values: write_enable 0, write_address 0, write_data 0, unit_ready 0, pending_mask 0, stall_pipeline 0, conflict_error 0; FIFO empty; counter 0.
- Pipe to port: 0 cycles, combinational.
- Unit to port: accepted at edge N, written at earliest in cycle N+1. The FIFO has no bypass.
- Enqueue and dequeue in the same cycle on a non-full FIFO keep the occupancy unchanged.
- Pointers wrap modulo FIFO_DEPTH, with an extra wrap bit for full/empty.
- An asynchronous reset mid-operation discards buffered entries. Their register writes are lost by design, because the pipeline is flushed with it.

## Structure
- Shared package regfile_pkg holds DATA_WIDTH and ADDRESS_SIZE defaults plus a write_request struct (address, data).
- Sub-module write_request_fifo: synchronous FIFO with valid/ready input, head/pop output, and per-entry valid/address taps for pending_mask.
- The arbiter, starve counter and mask decode live in the top level.

## Test plan
- Reset then idle → all outputs 0; unit_ready is 1 on the first cycle after reset deasserts.
- Unit writes r5=0x1234 with the pipe idle → accepted at edge N; cycle N+1 shows write_enable=1, write_address=5, write_data=0x1234; pending_mask[5] is 1 only during cycle N+1.
- Pipe writes r3=0xAAAA continuously while the unit writes r7=0x5555 → r7 stays buffered; stall_pipeline rises 5 cycles after enqueue; when the pipe drops, r7 is written and stall_pipeline falls the next cycle.
- Three back-to-back unit results with a continuous pipe → unit_ready=0 after 2 enqueues; the third waits; order is preserved once the port frees.
- Pipe write to r0 while the FIFO holds r9 → r9 is written in that same cycle; no r0 write occurs.
- Pipe write to r9 while r9 is pending → conflict_error=1 and stays 1 until reset; asserting reset mid-stream empties the FIFO and clears the mask.
